// File: rtl/debug_access_responder_if.sv
// rtl/debug_access_responder_if.sv - debugger request and core debug-port bundle
interface debug_access_responder_if;
  // debugger side
  logic [2:0]  mode;
  logic        tx_flag;
  logic [31:0] address_bridged;
  logic [31:0] data_bridged;
  logic [31:0] data_internal;
  logic        doneSending;
  logic        dbg_err;
  // instruction memory debug port
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  // data memory debug port
  logic [31:0] dmem_addr;
  logic        dmem_rd;
  logic        dmem_wr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_valid;
  // register file debug port and PC
  logic [4:0]  rf_addr;
  logic        rf_wr;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rdata;
  logic [31:0] pc_value;

  modport slave (
    input  mode, tx_flag, address_bridged, data_bridged,
    input  imem_rdata, imem_valid, dmem_rdata, dmem_valid, rf_rdata, pc_value,
    output data_internal, doneSending, dbg_err,
    output imem_addr, imem_rd, dmem_addr, dmem_rd, dmem_wr, dmem_wdata,
    output rf_addr, rf_wr, rf_wdata
  );

  modport master (
    output mode, tx_flag, address_bridged, data_bridged,
    output imem_rdata, imem_valid, dmem_rdata, dmem_valid, rf_rdata, pc_value,
    input  data_internal, doneSending, dbg_err,
    input  imem_addr, imem_rd, dmem_addr, dmem_rd, dmem_wr, dmem_wdata,
    input  rf_addr, rf_wr, rf_wdata
  );
endinterface

// File: rtl/debug_access_responder.sv
// rtl/debug_access_responder.sv - core-side debug access responder (imem/dmem/rf/PC)
module debug_access_responder #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
  input logic                       clk,
  input logic                       rst,
  debug_access_responder_if.slave   bus
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] M_IMEM_RD = 3'b001;
  localparam logic [2:0] M_DMEM_RD = 3'b010;
  localparam logic [2:0] M_DMEM_WR = 3'b011;
  localparam logic [2:0] M_RF_WR   = 3'b100;
  localparam logic [2:0] M_RF_RD   = 3'b101;
  localparam logic [2:0] M_PC_RD   = 3'b110;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    ACK      = 3'd3,
    HOLD     = 3'd4,
    WR       = 3'd5
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [2:0]  mode_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [CW-1:0] wait_cnt;
  logic [31:0] data_q;
  logic        err_q;
  logic        wr_armed;

  logic        is_rd_mode;
  logic        is_wr_mode;
  logic        rd_accept;
  logic        wr_accept;
  logic        q_is_imem;
  logic        q_is_dmem;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        timed_out;

  logic [31:0] imem_addr_o;
  logic        imem_rd_o;
  logic [31:0] dmem_addr_o;
  logic        dmem_rd_o;
  logic        dmem_wr_o;
  logic [31:0] dmem_wdata_o;
  logic [4:0]  rf_addr_o;
  logic        rf_wr_o;
  logic [31:0] rf_wdata_o;
  logic        done_o;

  // Classify the live mode and decide what IDLE accepts; reads win over writes.
  always_comb begin
    is_rd_mode = 1'b0;
    is_wr_mode = 1'b0;
    case (bus.mode)
      M_IMEM_RD, M_DMEM_RD, M_RF_RD, M_PC_RD: is_rd_mode = 1'b1;
      M_DMEM_WR, M_RF_WR:                     is_wr_mode = 1'b1;
      default: ;
    endcase
    rd_accept = (state == IDLE) && bus.tx_flag && is_rd_mode;
    wr_accept = (state == IDLE) && !rd_accept && is_wr_mode && wr_armed;
  end

  // Memory response selection uses the captured mode, never the live one.
  always_comb begin
    q_is_imem = (mode_q == M_IMEM_RD);
    q_is_dmem = (mode_q == M_DMEM_RD);
    mem_valid = q_is_imem ? bus.imem_valid : bus.dmem_valid;
    mem_rdata = q_is_imem ? bus.imem_rdata : bus.dmem_rdata;
    timed_out = (wait_cnt >= CW'(TIMEOUT - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rd_accept)      state_next = RD_ISSUE;
        else if (wr_accept) state_next = WR;
      end
      RD_ISSUE: state_next = (q_is_imem || q_is_dmem) ? RD_WAIT : ACK;
      RD_WAIT:  if (mem_valid || timed_out) state_next = ACK;
      ACK:      state_next = HOLD;
      HOLD:     if (!bus.tx_flag) state_next = IDLE;
      WR:       state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Output logic: strobes and port addresses are driven only in RD_ISSUE/WR.
  always_comb begin
    imem_addr_o  = '0;
    imem_rd_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_rd_o    = 1'b0;
    dmem_wr_o    = 1'b0;
    dmem_wdata_o = '0;
    rf_addr_o    = '0;
    rf_wr_o      = 1'b0;
    rf_wdata_o   = '0;
    done_o       = 1'b0;
    case (state)
      RD_ISSUE: begin
        if (q_is_imem) begin
          imem_addr_o = addr_q;
          imem_rd_o   = 1'b1;
        end else if (q_is_dmem) begin
          dmem_addr_o = addr_q;
          dmem_rd_o   = 1'b1;
        end else if (mode_q == M_RF_RD) begin
          rf_addr_o = addr_q[4:0];
        end
      end
      ACK: done_o = 1'b1;
      WR: begin
        if (mode_q == M_DMEM_WR) begin
          dmem_addr_o  = addr_q;
          dmem_wdata_o = wdata_q;
          dmem_wr_o    = 1'b1;
        end else begin
          rf_addr_o  = addr_q[4:0];
          rf_wdata_o = wdata_q;
          rf_wr_o    = (addr_q[4:0] != 5'd0);
        end
      end
      default: ;
    endcase
  end

  // Capture the request at acceptance so later mode/address changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (rd_accept || wr_accept) begin
      mode_q  <= bus.mode;
      addr_q  <= bus.address_bridged;
      wdata_q <= bus.data_bridged;
    end
  end

  // Count cycles spent waiting for memory valid; restart on every new wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    wait_cnt <= '0;
    else if (state == RD_WAIT)  wait_cnt <= wait_cnt + 1'b1;
    else                        wait_cnt <= '0;
  end

  // Read result and sticky error; result holds until the next read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (rd_accept) err_q <= 1'b0;
      if (state == RD_ISSUE) begin
        if (mode_q == M_RF_RD)
          data_q <= (addr_q[4:0] == 5'd0) ? 32'd0 : bus.rf_rdata;
        else if (mode_q == M_PC_RD)
          data_q <= bus.pc_value;
      end else if (state == RD_WAIT) begin
        if (mem_valid) begin
          data_q <= mem_rdata;
        end else if (timed_out) begin
          data_q <= ERR_WORD;
          err_q  <= 1'b1;
        end
      end
    end
  end

  // One write per entry into a write mode: re-armed by any non-write mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              wr_armed <= 1'b1;
    else if (state == WR) wr_armed <= 1'b0;
    else if (!is_wr_mode) wr_armed <= 1'b1;
  end

  assign bus.data_internal = data_q;
  assign bus.dbg_err       = err_q;
  assign bus.doneSending   = done_o;
  assign bus.imem_addr     = imem_addr_o;
  assign bus.imem_rd       = imem_rd_o;
  assign bus.dmem_addr     = dmem_addr_o;
  assign bus.dmem_rd       = dmem_rd_o;
  assign bus.dmem_wr       = dmem_wr_o;
  assign bus.dmem_wdata    = dmem_wdata_o;
  assign bus.rf_addr       = rf_addr_o;
  assign bus.rf_wr         = rf_wr_o;
  assign bus.rf_wdata      = rf_wdata_o;

endmodule

// File: tb/tb_debug_access_responder.sv
// tb/tb_debug_access_responder.sv - scoreboard bench for debug_access_responder
module tb_debug_access_responder;

  localparam logic [2:0] M_IDLE    = 3'b000;
  localparam logic [2:0] M_IMEM_RD = 3'b001;
  localparam logic [2:0] M_DMEM_RD = 3'b010;
  localparam logic [2:0] M_DMEM_WR = 3'b011;
  localparam logic [2:0] M_RF_WR   = 3'b100;
  localparam logic [2:0] M_RF_RD   = 3'b101;
  localparam logic [2:0] M_PC_RD   = 3'b110;
  localparam logic [2:0] M_BAD     = 3'b111;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rd_exp_t;

  typedef struct packed {
    logic        is_rf;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debug_access_responder_if bus();

  debug_access_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  rd_exp_t     exp_q[$];
  logic [31:0] rd_addr_q[$];
  wr_exp_t     wr_q[$];

  int done_cnt = 0;
  int rd_cnt   = 0;
  int dwr_cnt  = 0;
  int rfwr_cnt = 0;

  rd_exp_t     mon_e;
  wr_exp_t     mon_w;
  logic [31:0] mon_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT produces a result or strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.doneSending) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rd_data", bus.data_internal, mon_e.data);
          check("rd_err", {31'd0, bus.dbg_err}, {31'd0, mon_e.err});
        end
      end
      if (bus.imem_rd || bus.dmem_rd) begin
        rd_cnt++;
        mon_a = bus.imem_rd ? bus.imem_addr : bus.dmem_addr;
        if (rd_addr_q.size() == 0) check("rd_strobe_unexpected", 1, 0);
        else check("rd_addr", mon_a, rd_addr_q.pop_front());
      end
      if (bus.dmem_wr || bus.rf_wr) begin
        if (bus.dmem_wr) dwr_cnt++;
        if (bus.rf_wr) rfwr_cnt++;
        if (wr_q.size() == 0) begin
          check("wr_unexpected", 1, 0);
        end else begin
          mon_w = wr_q.pop_front();
          check("wr_kind", {31'd0, bus.rf_wr}, {31'd0, mon_w.is_rf});
          if (mon_w.is_rf) begin
            check("rf_wr_addr", {27'd0, bus.rf_addr}, mon_w.addr);
            check("rf_wr_data", bus.rf_wdata, mon_w.data);
          end else begin
            check("dmem_wr_addr", bus.dmem_addr, mon_w.addr);
            check("dmem_wr_data", bus.dmem_wdata, mon_w.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int start, input int budget, output int lat);
    lat = 0;
    while (done_cnt == start && lat < budget) begin
      tick();
      lat++;
    end
    if (done_cnt == start) check("done_wait_expired", 0, 1);
  endtask

  task automatic wait_rd_strobe(input int start);
    int waited = 0;
    while (rd_cnt == start && waited < 10) begin
      tick();
      waited++;
    end
    check("rd_strobe_seen", rd_cnt - start, 1);
  endtask

  task automatic reg_read(input logic [2:0] m, input logic [31:0] a, input logic [31:0] exp_data);
    rd_exp_t e;
    int start;
    int lat;
    e.data = exp_data;
    e.err  = 1'b0;
    exp_q.push_back(e);
    start = done_cnt;
    bus.mode = m;
    bus.address_bridged = a;
    bus.tx_flag = 1'b1;
    wait_done(start, 10, lat);
    check("reg_latency", lat, 2);
    repeat (4) tick();
    check("reg_single_done", done_cnt - start, 1);
    bus.mode = M_IDLE;
    bus.tx_flag = 1'b0;
    repeat (2) tick();
  endtask

  task automatic mem_read(input logic [2:0] m, input logic [31:0] a, input int dly,
                          input logic [31:0] rdata, input bit respond);
    rd_exp_t e;
    int start_done;
    int start_rd;
    int lat;
    e.data = respond ? rdata : 32'hDEADBEEF;
    e.err  = !respond;
    exp_q.push_back(e);
    rd_addr_q.push_back(a);
    start_done = done_cnt;
    start_rd = rd_cnt;
    bus.mode = m;
    bus.address_bridged = a;
    bus.tx_flag = 1'b1;
    wait_rd_strobe(start_rd);
    if (respond) begin
      repeat (dly) tick();
      bus.mode = M_RF_RD;
      bus.address_bridged = 32'h1F;
      if (m == M_IMEM_RD) begin
        bus.imem_rdata = rdata;
        bus.imem_valid = 1'b1;
      end else begin
        bus.dmem_rdata = rdata;
        bus.dmem_valid = 1'b1;
      end
      tick();
      bus.imem_valid = 1'b0;
      bus.dmem_valid = 1'b0;
      wait_done(start_done, 20, lat);
    end else begin
      wait_done(start_done, 400, lat);
      check("timeout_latency", lat, 256);
    end
    repeat (3) tick();
    check("mem_single_strobe", rd_cnt - start_rd, 1);
    check("mem_single_done", done_cnt - start_done, 1);
    bus.mode = M_IDLE;
    bus.tx_flag = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    int start;
    bus.mode = M_IDLE;
    bus.tx_flag = 1'b0;
    bus.address_bridged = '0;
    bus.data_bridged = '0;
    bus.imem_rdata = '0;
    bus.imem_valid = 1'b0;
    bus.dmem_rdata = '0;
    bus.dmem_valid = 1'b0;
    bus.rf_rdata = '0;
    bus.pc_value = '0;

    repeat (2) tick();
    check("reset_data", bus.data_internal, 0);
    check("reset_done_err", {30'd0, bus.doneSending, bus.dbg_err}, 0);
    check("reset_strobes", {27'd0, bus.imem_rd, bus.dmem_rd, bus.dmem_wr, bus.rf_wr, |bus.rf_addr}, 0);
    rst = 1'b0;
    repeat (2) tick();

    // register file, x0 and PC reads
    bus.rf_rdata = 32'h1234_5678;
    reg_read(M_RF_RD, 32'd5, 32'h1234_5678);
    bus.rf_rdata = 32'hFFFF_FFFF;
    reg_read(M_RF_RD, 32'd0, 32'd0);
    bus.pc_value = 32'h1000_0040;
    reg_read(M_PC_RD, 32'd0, 32'h1000_0040);

    // memory reads with a mid-read mode/address change
    mem_read(M_DMEM_RD, 32'h40, 4, 32'hA5A5_0001, 1'b1);
    mem_read(M_IMEM_RD, 32'h100, 1, 32'h0000_0013, 1'b1);

    // imem read that never gets valid
    mem_read(M_IMEM_RD, 32'h200, 0, 32'd0, 1'b0);
    check("err_sticky", {31'd0, bus.dbg_err}, 1);
    check("err_word_held", bus.data_internal, 32'hDEADBEEF);
    bus.rf_rdata = 32'h0BAD_F00D;
    reg_read(M_RF_RD, 32'd9, 32'h0BAD_F00D);
    check("err_cleared", {31'd0, bus.dbg_err}, 0);

    // unlisted/idle modes with tx_flag raised
    start = done_cnt;
    bus.mode = M_BAD;
    bus.tx_flag = 1'b1;
    repeat (6) tick();
    bus.mode = M_IDLE;
    repeat (4) tick();
    check("bad_mode_no_done", done_cnt - start, 0);
    bus.tx_flag = 1'b0;
    tick();

    // dmem writes: one per mode entry
    start = dwr_cnt;
    wr_q.push_back('{is_rf: 1'b0, addr: 32'h80, data: 32'h0000_CAFE});
    bus.mode = M_DMEM_WR;
    bus.address_bridged = 32'h80;
    bus.data_bridged = 32'h0000_CAFE;
    repeat (20) tick();
    check("dmem_wr_once", dwr_cnt - start, 1);
    bus.mode = M_IDLE;
    repeat (2) tick();
    wr_q.push_back('{is_rf: 1'b0, addr: 32'h84, data: 32'h0000_BEEF});
    bus.mode = M_DMEM_WR;
    bus.address_bridged = 32'h84;
    bus.data_bridged = 32'h0000_BEEF;
    repeat (5) tick();
    check("dmem_wr_rearm", dwr_cnt - start, 2);
    bus.mode = M_IDLE;
    repeat (2) tick();

    // rf writes: x0 suppressed, x3 written once
    start = rfwr_cnt;
    bus.mode = M_RF_WR;
    bus.address_bridged = 32'd0;
    bus.data_bridged = 32'h7777_7777;
    repeat (5) tick();
    check("rf_wr_x0", rfwr_cnt - start, 0);
    bus.mode = M_IDLE;
    repeat (2) tick();
    wr_q.push_back('{is_rf: 1'b1, addr: 32'd3, data: 32'h5A5A_1234});
    bus.mode = M_RF_WR;
    bus.address_bridged = 32'd3;
    bus.data_bridged = 32'h5A5A_1234;
    repeat (5) tick();
    check("rf_wr_x3", rfwr_cnt - start, 1);
    bus.mode = M_IDLE;
    repeat (2) tick();

    // reset while waiting for dmem valid
    rd_addr_q.push_back(32'h44);
    start = done_cnt;
    bus.mode = M_DMEM_RD;
    bus.address_bridged = 32'h44;
    bus.tx_flag = 1'b1;
    wait_rd_strobe(rd_cnt);
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("rst_data", bus.data_internal, 0);
    check("rst_done_err", {30'd0, bus.doneSending, bus.dbg_err}, 0);
    check("rst_strobes", {28'd0, bus.imem_rd, bus.dmem_rd, bus.dmem_wr, bus.rf_wr}, 0);
    bus.mode = M_IDLE;
    bus.tx_flag = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_no_done", done_cnt - start, 0);
    bus.rf_rdata = 32'h600D_0007;
    reg_read(M_RF_RD, 32'd7, 32'h600D_0007);

    check("rd_queue_empty", exp_q.size(), 0);
    check("rd_addr_queue_empty", rd_addr_q.size(), 0);
    check("wr_queue_empty", wr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
